counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 101 ++++++++++
 tb/tb_counter_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Command-driven up/down counter: loads a start value, steps toward a latched
// target under en, pulses done on arrival, and flags modulo wrap-around.
module counter_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrapped
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_nxt;
  logic [WIDTH-1:0] step_val;
  logic             dir_q;
  logic             dir_nxt;
  logic             wrapped_nxt;
  logic             wrap_step;

  // State and datapath registers; status outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      target_q  <= '0;
      dir_q     <= 1'b1;
      wrapped   <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      target_q  <= target_nxt;
      dir_q     <= dir_nxt;
      wrapped   <= wrapped_nxt;
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt == RUN);
      done      <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath update; abort outranks both the step and the target match.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    target_nxt  = target_q;
    dir_nxt     = dir_q;
    wrapped_nxt = wrapped;
    step_val    = dir_q ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    wrap_step   = dir_q ? (count == '1) : (count == '0);

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          count_nxt   = cmd_start;
          target_nxt  = cmd_target;
          dir_nxt     = cmd_dir;
          wrapped_nxt = 1'b0;
          state_nxt   = (cmd_start == cmd_target) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (en) begin
          count_nxt = step_val;
          if (wrap_step) begin
            wrapped_nxt = 1'b1;
          end
          if (step_val == target_q) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and randomized checks of counter_sequencer against a distance/step-count
// reference model.
module tb_counter_sequencer;

  localparam int unsigned W = 4;
  localparam int M = 16;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_start;
  logic [W-1:0] cmd_target;
  logic         cmd_dir;
  logic         en;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         wrapped;

  bit clk_run;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .en(en), .abort(abort), .count(count), .busy(busy), .done(done),
    .wrapped(wrapped)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  int n_checks;
  int n_fail;

  // Model: phase 0=idle, 1=running, 2=done pulse; progress kept as steps taken
  // from the start value toward a precomputed modulo distance.
  int ph;
  int m_start;
  int m_dir;
  int m_dist;
  int m_steps;

  function automatic int m_count();
    int v;
    v = (m_dir != 0) ? (m_start + m_steps) : (m_start - m_steps);
    return ((v % M) + M) % M;
  endfunction

  function automatic int m_wrap();
    if (m_dir != 0) return (m_start + m_steps >= M) ? 1 : 0;
    return (m_steps > m_start) ? 1 : 0;
  endfunction

  task automatic model_reset();
    ph = 0; m_start = 0; m_dir = 1; m_dist = 0; m_steps = 0;
  endtask

  task automatic model_edge();
    if (ph == 0) begin
      if (cmd_valid) begin
        m_start = int'(cmd_start);
        m_dir   = int'(cmd_dir);
        m_dist  = cmd_dir ? ((int'(cmd_target) - int'(cmd_start) + M) % M)
                          : ((int'(cmd_start) - int'(cmd_target) + M) % M);
        m_steps = 0;
        ph      = (m_dist == 0) ? 2 : 1;
      end
    end else if (abort || ph == 2) begin
      ph = 0;
    end else if (en) begin
      m_steps++;
      if (m_steps == m_dist) ph = 2;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",     int'(count),     m_count());
    chk("cmd_ready", int'(cmd_ready), (ph == 0) ? 1 : 0);
    chk("busy",      int'(busy),      (ph == 1) ? 1 : 0);
    chk("done",      int'(done),      (ph == 2) ? 1 : 0);
    chk("wrapped",   int'(wrapped),   m_wrap());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic offer(input int s, input int t, input bit d);
    cmd_valid  = 1'b1;
    cmd_start  = W'(s);
    cmd_target = W'(t);
    cmd_dir    = d;
  endtask

  task automatic scramble_cmd();
    cmd_start  = W'($urandom);
    cmd_target = W'($urandom);
    cmd_dir    = 1'($urandom);
  endtask

  initial begin
    int down_exp [4];
    int gate_en [4];
    int gate_exp [4];
    n_checks = 0; n_fail = 0;
    down_exp = '{1, 0, 15, 14};
    gate_en  = '{1, 0, 0, 1};
    gate_exp = '{1, 1, 1, 2};
    clk_run = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_target = '0;
    cmd_dir = 1'b0; en = 1'b0; abort = 1'b0;
    model_reset();

    // Reset with clock stopped
    #1;
    check_all();
    #2;
    reset = 1'b0;
    clk_run = 1;

    // Up count 3 -> 7
    offer(3, 7, 1'b1); en = 1'b1;
    cycle();
    chk("up_accept_count", int'(count), 3);
    cmd_valid = 1'b0; scramble_cmd();
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("up_count", int'(count), 3 + i);
      chk("up_done", int'(done), (i == 4) ? 1 : 0);
    end
    cycle();
    chk("up_ready_again", int'(cmd_ready), 1);

    // Down count with wrap 2 -> 14
    offer(2, 14, 1'b0);
    cycle();
    cmd_valid = 1'b0; scramble_cmd();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("down_count", int'(count), down_exp[i]);
      chk("down_wrapped", int'(wrapped), (i >= 2) ? 1 : 0);
    end
    chk("down_done", int'(done), 1);
    cycle();

    // Zero-length command
    offer(9, 9, 1'b1);
    cycle();
    chk("zero_done", int'(done), 1);
    chk("zero_count", int'(count), 9);
    cmd_valid = 1'b0;
    cycle();

    // Enable gating
    offer(0, 2, 1'b1); en = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = gate_en[i] ? 1'b1 : 1'b0;
      cycle();
      chk("gate_count", int'(count), gate_exp[i]);
    end
    chk("gate_done", int'(done), 1);
    en = 1'b1;
    cycle();

    // Abort at count 5 with a command held pending
    offer(0, 15, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && int'(count) != 5; i++) cycle();
    chk("abort_reach5", int'(count), 5);
    abort = 1'b1; offer(1, 4, 1'b1);
    cycle();
    chk("abort_count", int'(count), 5);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_no_done", int'(done), 0);
    abort = 1'b0;
    cycle();
    chk("held_cmd_accepted", int'(count), 1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && ph != 0; i++) cycle();
    chk("abort_cmd_finished", int'(cmd_ready), 1);

    // Abort together with a command in idle is ignored
    abort = 1'b1; offer(6, 6, 1'b0);
    cycle();
    chk("idle_abort_accept", int'(done), 1);
    abort = 1'b0; cmd_valid = 1'b0;
    cycle();

    // Reset at count 3
    offer(0, 10, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    repeat (3) cycle();
    chk("pre_reset_count", int'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("reset_count", int'(count), 0);
    #1;
    reset = 1'b0;
    repeat (2) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(3) == 0);
      scramble_cmd();
      en    = ($urandom_range(3) != 0);
      abort = ($urandom_range(19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
